// File: rtl/fp_pkg.sv
// fp_pkg: shared encodings, operand classes and canonical
// special-value helpers for the IEEE-754 datapaths.
package fp_pkg;

  localparam logic [1:0] RND_RNE = 2'b00;
  localparam logic [1:0] RND_RTZ = 2'b01;
  localparam logic [1:0] RND_RUP = 2'b10;
  localparam logic [1:0] RND_RDN = 2'b11;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  // Helpers return the encoding in the low ew+sw+1 bits;
  // callers size-cast to their word width.
  function automatic logic [63:0] fp_qnan(
    input int ew,
    input int sw
  );
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd1) << sw)
      | (64'd1 << (sw - 1));
    return r;
  endfunction

  function automatic logic [63:0] fp_inf(
    input logic s,
    input int   ew,
    input int   sw
  );
    logic [63:0] r;
    r = ({63'd0, s} << (ew + sw))
      | (((64'd1 << ew) - 64'd1) << sw);
    return r;
  endfunction

  function automatic logic [63:0] fp_max(
    input logic s,
    input int   ew,
    input int   sw
  );
    logic [63:0] r;
    r = ({63'd0, s} << (ew + sw))
      | (((64'd1 << ew) - 64'd2) << sw)
      | ((64'd1 << sw) - 64'd1);
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_round_pack.sv
// fp_round_pack: normalise, round, range-check and pack a raw
// significand product. Flags only exist with FP_MULT_FLAGS_EN.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23
) (
  input  logic                          sign,
  input  logic [1:0]                    rnd,
  input  logic signed [EXP_WIDTH+1:0]   exp,
  input  logic [2*SIG_WIDTH+1:0]        prod,
  output logic [EXP_WIDTH+SIG_WIDTH:0]  result,
  output logic [3:0]                    flags
);

  localparam int W   = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int PW  = 2 * SIG_WIDTH + 2;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] EXP_MAX =
    EW2'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;

  logic [PW-1:0]          norm;
  logic [SIG_WIDTH-1:0]   frac;
  logic [SIG_WIDTH-1:0]   frac_r;
  logic [SIG_WIDTH+1:0]   sum;
  logic signed [EW2-1:0]  exp_n;
  logic signed [EW2-1:0]  exp_r;
  logic g, t, inc, ovf, unf, to_inf;

  always_comb begin
    norm  = prod[PW-1] ? prod : (prod << 1);
    exp_n = exp + EW2'(prod[PW-1]);
    frac  = norm[PW-2 -: SIG_WIDTH];
    g     = norm[PW-2-SIG_WIDTH];
    t     = |norm[PW-3-SIG_WIDTH:0];
    unique case (rnd)
      RND_RNE: inc = g & (frac[0] | t);
      RND_RUP: inc = (g | t) & ~sign;
      RND_RDN: inc = (g | t) & sign;
      default: inc = 1'b0;
    endcase
    // a rounding carry leaves 1.000..0 one binade up
    sum    = {2'b01, frac} + (SIG_WIDTH+2)'(inc);
    frac_r = sum[SIG_WIDTH+1] ? sum[SIG_WIDTH:1]
                              : sum[SIG_WIDTH-1:0];
    exp_r  = exp_n + EW2'(sum[SIG_WIDTH+1]);
    ovf    = exp_r >= EXP_MAX;
    unf    = exp_r <= EXP_ZERO;
    to_inf = (rnd == RND_RNE)
           | ((rnd == RND_RUP) & ~sign)
           | ((rnd == RND_RDN) & sign);
    if (ovf) begin
      result = to_inf ? W'(fp_inf(sign, EXP_WIDTH, SIG_WIDTH))
                      : W'(fp_max(sign, EXP_WIDTH, SIG_WIDTH));
    end else if (unf) begin
      result = {sign, {(W-1){1'b0}}};
    end else begin
      result = {sign, exp_r[EXP_WIDTH-1:0], frac_r};
    end
  end

`ifdef FP_MULT_FLAGS_EN
  always_comb begin
    flags          = '0;
    flags[FLG_OVF] = ovf;
    flags[FLG_UNF] = unf;
    flags[FLG_INX] = ovf | unf | g | t;
  end
`else
  assign flags = '0;
`endif

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754 multiplier with valid/ready.
// Define FP_MULT_FLAGS_EN to build the exception flags.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_WIDTH = 8,
  parameter  int SIG_WIDTH = 23,
  localparam int WIDTH     = 1 + EXP_WIDTH + SIG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int EW2 = EXP_WIDTH + 2;
  localparam int MW  = SIG_WIDTH + 1;
  localparam int PW  = 2 * SIG_WIDTH + 2;
  localparam logic [EW2-1:0] BIAS =
    EW2'((1 << (EXP_WIDTH - 1)) - 1);

  logic adv, v1, v2;
  fp_class_e ca, cb;

  logic             s1_sign;
  logic [1:0]       s1_rnd;
  logic [EW2-1:0]   s1_exp;
  fp_class_e        s1_ca, s1_cb;
  logic [MW-1:0]    s1_ma, s1_mb;

  logic                  s2_sign;
  logic [1:0]            s2_rnd;
  logic signed [EW2-1:0] s2_exp;
  fp_class_e             s2_ca, s2_cb;
  logic [PW-1:0]         s2_prod;

  logic [WIDTH-1:0] rp_result, s3_result;
  logic [3:0]       rp_flags;
  logic is_nan, is_inf, is_zero;

  function automatic fp_class_e classify(
    input logic [WIDTH-1:0] x
  );
    if (x[WIDTH-2:SIG_WIDTH] == '0) return ZERO;
    if (&x[WIDTH-2:SIG_WIDTH])
      return (x[SIG_WIDTH-1:0] == '0) ? INF : NAN;
    return NORM;
  endfunction

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign ca       = classify(a);
  assign cb       = classify(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) result <= s3_result;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= a[WIDTH-1] ^ b[WIDTH-1];
      s1_rnd  <= rnd;
      s1_exp  <= EW2'(a[WIDTH-2:SIG_WIDTH])
               + EW2'(b[WIDTH-2:SIG_WIDTH]) - BIAS;
      s1_ca   <= ca;
      s1_cb   <= cb;
      s1_ma   <= {1'b1, a[SIG_WIDTH-1:0]};
      s1_mb   <= {1'b1, b[SIG_WIDTH-1:0]};
      s2_sign <= s1_sign;
      s2_rnd  <= s1_rnd;
      s2_exp  <= s1_exp;
      s2_ca   <= s1_ca;
      s2_cb   <= s1_cb;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  fp_round_pack #(
    .EXP_WIDTH (EXP_WIDTH),
    .SIG_WIDTH (SIG_WIDTH)
  ) u_round_pack (
    .sign   (s2_sign),
    .rnd    (s2_rnd),
    .exp    (s2_exp),
    .prod   (s2_prod),
    .result (rp_result),
    .flags  (rp_flags)
  );

  assign is_nan  = (s2_ca == NAN) | (s2_cb == NAN)
                 | ((s2_ca == ZERO) & (s2_cb == INF))
                 | ((s2_ca == INF) & (s2_cb == ZERO));
  assign is_inf  = (s2_ca == INF) | (s2_cb == INF);
  assign is_zero = (s2_ca == ZERO) | (s2_cb == ZERO);

  always_comb begin
    s3_result = rp_result;
    if (is_nan)
      s3_result = WIDTH'(fp_qnan(EXP_WIDTH, SIG_WIDTH));
    else if (is_inf)
      s3_result = WIDTH'(fp_inf(s2_sign, EXP_WIDTH, SIG_WIDTH));
    else if (is_zero)
      s3_result = {s2_sign, {(WIDTH-1){1'b0}}};
  end

`ifdef FP_MULT_FLAGS_EN
  logic [3:0] s3_flags;

  always_comb begin
    s3_flags = rp_flags;
    if (is_nan) begin
      s3_flags          = '0;
      s3_flags[FLG_INV] = 1'b1;
    end else if (is_inf | is_zero) begin
      s3_flags = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            flags <= '0;
    else if (adv && v2) flags <= s3_flags;
  end
`else
  // fp_round_pack ties its flags to zero in this build
  assign flags = rp_flags;
`endif

endmodule
